// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the requester command/response port and the APB initiator port of
// apb_master_bridge. Signal names are written from the bridge's point of view
// (_i = into the bridge, _o = out of the bridge).
//   master : the bridge itself
//   slave  : everything around it (requester plus APB target)
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int addr_width = 12,
    parameter int data_width = 32
);
    // Command port
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [addr_width-1:0] req_addr_i;
    logic [data_width-1:0] req_wdata_i;

    // Response port
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [data_width-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    // APB initiator port
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [addr_width-1:0] paddr_o;
    logic [data_width-1:0] pwdata_o;
    logic [data_width-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );
endinterface

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB initiator. A request accepted in IDLE is replayed on
// APB as one SETUP cycle followed by ACCESS cycles until pready, and the
// completion is parked on the response port until the requester takes it.
// A programmable ACCESS timeout ends transfers to a slave that never answers;
// the response then carries err=1, timeout=1 and zero read data.
// Everything leaving the block is a flop except req_ready_o, which is a pure
// decode of the state so a request can be taken on the first IDLE cycle.
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int addr_width     = 12,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 16   // 0 disables the timeout, must be < 256
) (
    input  logic                pclk,
    input  logic                preset_i,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Timeout fires on the last allowed ACCESS cycle, so ACCESS lasts exactly
    // timeout_cycles cycles when the slave never answers.
    localparam bit       TO_EN   = (timeout_cycles != 0);
    localparam logic [7:0] TO_LAST = (timeout_cycles == 0) ? 8'd0
                                                            : 8'(timeout_cycles - 1);

    state_t                state_reg;
    logic [7:0]            wait_cnt_reg;

    logic                  psel_reg;
    logic                  penable_reg;
    logic                  pwrite_reg;
    logic [addr_width-1:0] paddr_reg;
    logic [data_width-1:0] pwdata_reg;

    logic                  rsp_valid_reg;
    logic [data_width-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;
    logic                  rsp_timeout_reg;

    // Transfer sequencer: state, wait counter and every registered output.
    always_ff @(posedge pclk or negedge preset_i) begin
        if (!preset_i) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= 8'd0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // req_ready is high in IDLE, so valid alone is a handshake.
                    if (bus.req_valid_i) begin
                        pwrite_reg   <= bus.req_write_i;
                        paddr_reg    <= bus.req_addr_i;
                        pwdata_reg   <= bus.req_wdata_i;
                        psel_reg     <= 1'b1;
                        penable_reg  <= 1'b0;
                        wait_cnt_reg <= 8'd0;
                        state_reg    <= SETUP;
                    end
                end

                SETUP: begin
                    penable_reg  <= 1'b1;
                    wait_cnt_reg <= 8'd0;
                    state_reg    <= ACCESS;
                end

                ACCESS: begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    // pready is checked first so a reply on the final
                    // allowed cycle still completes normally.
                    if (bus.pready_i) begin
                        rsp_rdata_reg   <= pwrite_reg ? '0 : bus.prdata_i;
                        rsp_err_reg     <= bus.pslverr_i;
                        rsp_timeout_reg <= 1'b0;
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RESP;
                    end else if (TO_EN && (wait_cnt_reg == TO_LAST)) begin
                        rsp_rdata_reg   <= '0;
                        rsp_err_reg     <= 1'b1;
                        rsp_timeout_reg <= 1'b1;
                        psel_reg        <= 1'b0;
                        penable_reg     <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= RESP;
                    end
                end

                RESP: begin
                    // Response and APB address/data hold their values until
                    // the requester takes the response.
                    if (bus.rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        wait_cnt_reg  <= 8'd0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Only IDLE accepts; a response being consumed blocks acceptance that cycle.
    always_comb begin
        bus.req_ready_o = (state_reg == IDLE);
    end

    assign bus.psel_o        = psel_reg;
    assign bus.penable_o     = penable_reg;
    assign bus.pwrite_o      = pwrite_reg;
    assign bus.paddr_o       = paddr_reg;
    assign bus.pwdata_o      = pwdata_reg;
    assign bus.rsp_valid_o   = rsp_valid_reg;
    assign bus.rsp_rdata_o   = rsp_rdata_reg;
    assign bus.rsp_err_o     = rsp_err_reg;
    assign bus.rsp_timeout_o = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
// Directed and randomized transfers against apb_master_bridge. The expected
// timeline of each transfer (cycle of SETUP, length of ACCESS, response
// contents) is derived from the transfer parameters by plain arithmetic.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int T  = 16;

    logic pclk     = 1'b0;
    logic preset_i = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int xfer_no    = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge_if #(.addr_width(AW), .data_width(DW)) bus ();

    apb_master_bridge #(
        .addr_width    (AW),
        .data_width    (DW),
        .timeout_cycles(T)
    ) dut (
        .pclk    (pclk),
        .preset_i(preset_i),
        .bus     (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // One complete transfer, started at a negedge with the bridge in IDLE.
    // Cycle 0 is the handshake cycle; cycle 1 is SETUP; ACCESS follows; the
    // response appears in cycle 3+waits, or 2+T when the slave stays silent
    // for all T ACCESS cycles (waits >= T).
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd, input bit serr,
                        input int stall, input bit pend);
        bit              to;
        int              r;
        logic [DW-1:0]   exp_rd;
        bit              exp_err;
        to      = (T != 0) && (waits >= T);
        r       = to ? (2 + T) : (3 + waits);
        exp_rd  = (to || wr) ? '0 : rd;
        exp_err = to ? 1'b1 : serr;

        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        bus.pready_i    = 1'b0;
        chk("req_ready_idle", 32'(bus.req_ready_o), 32'd1);

        for (int c = 1; c <= r; c++) begin
            tick();
            if (c == 1) begin
                // Scramble request fields after acceptance; APB must not follow.
                bus.req_valid_i = 1'b0;
                bus.req_addr_i  = AW'($urandom);
                bus.req_wdata_i = $urandom;
                bus.req_write_i = 1'($urandom);
            end
            if (c < r) begin
                chk("psel_busy",    32'(bus.psel_o),      32'd1);
                chk("penable",      32'(bus.penable_o),   (c >= 2) ? 32'd1 : 32'd0);
                chk("rsp_valid_lo", 32'(bus.rsp_valid_o), 32'd0);
                chk("req_ready_bz", 32'(bus.req_ready_o), 32'd0);
                chk("paddr",        32'(bus.paddr_o),     32'(a));
                chk("pwrite",       32'(bus.pwrite_o),    32'(wr));
                chk("pwdata",       bus.pwdata_o,         wd);
                if (c >= 2) begin
                    bus.pready_i  = ((c - 1) == (waits + 1));
                    bus.prdata_i  = bus.pready_i ? rd : $urandom;
                    bus.pslverr_i = bus.pready_i ? serr : 1'($urandom);
                end
            end else begin
                bus.pready_i  = 1'b0;
                bus.pslverr_i = 1'b0;
                chk("psel_done",     32'(bus.psel_o),        32'd0);
                chk("penable_done",  32'(bus.penable_o),     32'd0);
                chk("rsp_valid",     32'(bus.rsp_valid_o),   32'd1);
                chk("rsp_rdata",     bus.rsp_rdata_o,        exp_rd);
                chk("rsp_err",       32'(bus.rsp_err_o),     32'(exp_err));
                chk("rsp_timeout",   32'(bus.rsp_timeout_o), 32'(to));
                chk("paddr_hold",    32'(bus.paddr_o),       32'(a));
            end
        end

        bus.rsp_ready_i = 1'b0;
        if (pend) begin
            bus.req_valid_i = 1'b1;
            bus.req_write_i = 1'b0;
            bus.req_addr_i  = 12'h3FC;
            bus.req_wdata_i = 32'h0000_1234;
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_valid",   32'(bus.rsp_valid_o),   32'd1);
            chk("stall_rdata",   bus.rsp_rdata_o,        exp_rd);
            chk("stall_err",     32'(bus.rsp_err_o),     32'(exp_err));
            chk("stall_timeout", 32'(bus.rsp_timeout_o), 32'(to));
            chk("stall_ready",   32'(bus.req_ready_o),   32'd0);
            chk("stall_psel",    32'(bus.psel_o),        32'd0);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        chk("consumed_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("consumed_ready", 32'(bus.req_ready_o), 32'd1);
        chk("consumed_psel",  32'(bus.psel_o),      32'd0);
        xfer_no++;
        $display("xfer %0d wr=%0d addr=%h wdata=%h waits=%0d rd=%h serr=%0d stall=%0d -> rdata=%h err=%0d to=%0d",
                 xfer_no, wr, a, wd, waits, rd, serr, stall, exp_rd, exp_err, to);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;

        // Reset state
        #1 preset_i = 1'b0;
        #2;
        chk("rst_psel",      32'(bus.psel_o),        32'd0);
        chk("rst_penable",   32'(bus.penable_o),     32'd0);
        chk("rst_pwrite",    32'(bus.pwrite_o),      32'd0);
        chk("rst_paddr",     32'(bus.paddr_o),       32'd0);
        chk("rst_pwdata",    bus.pwdata_o,           32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o),   32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o,        32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err_o),     32'd0);
        chk("rst_rsp_to",    32'(bus.rsp_timeout_o), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready_o),   32'd1);
        tick();
        tick();
        preset_i = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);

        // Write with one wait state
        xfer(1'b1, 12'h084, 32'h0000_00AB, 1, 32'h5555_AAAA, 1'b0, 0, 1'b0);
        // Read with three wait states
        xfer(1'b0, 12'h040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        // Slave error, then a back-to-back write
        xfer(1'b0, 12'h010, 32'h0, 0, 32'h1357_9BDF, 1'b1, 0, 1'b0);
        xfer(1'b1, 12'h014, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 0, 1'b0);
        // Timeout: silent slave, then pready on the last allowed cycle
        xfer(1'b0, 12'h020, 32'h0, 100, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        xfer(1'b0, 12'h024, 32'h0, T - 1, 32'h0BAD_CAFE, 1'b0, 0, 1'b0);
        // Response stall with a request waiting behind it
        xfer(1'b0, 12'h100, 32'h0, 2, 32'h8765_4321, 1'b0, 5, 1'b1);
        xfer(1'b0, 12'h3FC, 32'h0000_1234, 0, 32'h2468_ACE0, 1'b0, 0, 1'b0);

        // Asynchronous reset during ACCESS
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 12'h0C0;
        bus.req_wdata_i = 32'h1111_2222;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        chk("pre_rst_psel",    32'(bus.psel_o),    32'd1);
        chk("pre_rst_penable", 32'(bus.penable_o), 32'd1);
        #2 preset_i = 1'b0;
        #1;
        chk("async_psel",      32'(bus.psel_o),      32'd0);
        chk("async_penable",   32'(bus.penable_o),   32'd0);
        chk("async_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge pclk);
        tick();
        preset_i = 1'b1;
        tick();
        chk("rst_no_rsp",  32'(bus.rsp_valid_o), 32'd0);
        chk("rst_ready",   32'(bus.req_ready_o), 32'd1);
        xfer(1'b1, 12'h0C4, 32'h3333_4444, 1, 32'h0, 1'b0, 0, 1'b0);

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            int w;
            w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T - 3, T + 4))
                                            : int'($urandom_range(0, 3));
            xfer(1'($urandom), AW'($urandom), $urandom, w, $urandom,
                 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
